// File: rtl/relu_ctrl_pkg.sv
// Shared FSM encoding and helper functions for the burst-granular ReLU arbiter.
package relu_ctrl_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } state_t;

  localparam int MAX_REQ = 32;

  // Callers sign-extend into int and truncate the result back to their own width.
  function automatic int relu_f(input int x);
    return (x > 0) ? x : 0;
  endfunction

  // Round-robin pick: first valid above last, otherwise wrap to the lowest valid.
  function automatic int rr_pick(input logic [MAX_REQ-1:0] valid, input int last);
    logic [MAX_REQ-1:0] upper;
    int                 pick;
    logic               found;
    upper = valid & ~((MAX_REQ'(2) << last) - MAX_REQ'(1));
    pick  = 0;
    found = 1'b0;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (!found && upper[i]) begin
        pick  = i;
        found = 1'b1;
      end
    end
    for (int i = 0; i < MAX_REQ; i++) begin
      if (!found && valid[i]) begin
        pick  = i;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/relu_stage.sv
// Registered ReLU output stage: loads a new tagged beat on load, drains on out_ready.
module relu_stage
  import relu_ctrl_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ID_W   = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              load,
  input  logic              out_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [ID_W-1:0]   in_id,
  input  logic              in_last,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [ID_W-1:0]   out_id,
  output logic              out_last
);

  logic signed [DATA_W-1:0] x_s;
  logic        [DATA_W-1:0] y_next;

  assign x_s    = in_data;
  assign y_next = DATA_W'(relu_f(int'(x_s)));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_id    <= '0;
      out_last  <= 1'b0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= y_next;
      out_id    <= in_id;
      out_last  <= in_last;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/relu_burst_arbiter.sv
// Round-robin, burst-locked arbiter feeding one registered ReLU stage.
module relu_burst_arbiter
  import relu_ctrl_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 8,
  parameter int BURST_LEN = 4,
  parameter int ID_W      = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_W-1:0]         out_data,
  output logic [ID_W-1:0]           out_id,
  output logic                      out_last,
  output logic                      busy
);

  localparam int CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

  state_t            state_reg, state_next;
  logic [ID_W-1:0]   grant_reg, grant_next;
  logic [ID_W-1:0]   last_grant_reg, last_grant_next;
  logic [CNT_W-1:0]  beat_cnt_reg, beat_cnt_next;
  logic              out_en;
  logic              load;
  logic              load_last;
  logic [DATA_W-1:0] sel_data;

  assign out_en   = !out_valid || out_ready;
  assign sel_data = req_data[grant_reg*DATA_W +: DATA_W];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= ST_IDLE;
      grant_reg      <= '0;
      last_grant_reg <= ID_W'(NUM_REQ - 1);
      beat_cnt_reg   <= '0;
    end else begin
      state_reg      <= state_next;
      grant_reg      <= grant_next;
      last_grant_reg <= last_grant_next;
      beat_cnt_reg   <= beat_cnt_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    grant_next      = grant_reg;
    last_grant_next = last_grant_reg;
    beat_cnt_next   = beat_cnt_reg;
    req_ready       = '0;
    load            = 1'b0;
    load_last       = 1'b0;
    busy            = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (|req_valid) begin
          grant_next    = ID_W'(rr_pick(MAX_REQ'(req_valid), int'(last_grant_reg)));
          beat_cnt_next = '0;
          state_next    = ST_STREAM;
        end
      end
      ST_STREAM: begin
        busy                 = 1'b1;
        req_ready[grant_reg] = out_en;
        load_last            = (beat_cnt_reg == CNT_W'(BURST_LEN - 1));
        // Grant stays locked until the final beat transfers, even if valid drops.
        if (req_valid[grant_reg] && out_en) begin
          load = 1'b1;
          if (load_last) begin
            last_grant_next = grant_reg;
            beat_cnt_next   = '0;
            state_next      = ST_IDLE;
          end else begin
            beat_cnt_next = beat_cnt_reg + CNT_W'(1);
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  relu_stage #(
    .DATA_W (DATA_W),
    .ID_W   (ID_W)
  ) u_stage (
    .clk       (clk),
    .reset_n   (reset_n),
    .load      (load),
    .out_ready (out_ready),
    .in_data   (sel_data),
    .in_id     (grant_reg),
    .in_last   (load_last),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_id    (out_id),
    .out_last  (out_last)
  );

endmodule

// File: tb/tb_relu_burst_arbiter.sv
// Directed self-checking bench for relu_burst_arbiter (4 requesters, 8-bit, bursts of 4).
module tb_relu_burst_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic [1:0]  out_id;
  logic        out_last;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  relu_burst_arbiter #(
    .NUM_REQ   (4),
    .DATA_W    (8),
    .BURST_LEN (4),
    .ID_W      (2)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_id    (out_id),
    .out_last  (out_last),
    .busy      (busy)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input int i, input logic [7:0] v);
    req_data[i*8 +: 8] = v;
  endtask

  task automatic do_reset;
    reset_n   = 1'b0;
    req_valid = 4'h0;
    req_data  = 32'h0;
    out_ready = 1'b1;
    step();
    step();
    reset_n = 1'b1;
  endtask

  task automatic test_reset;
    reset_n   = 1'b0;
    req_valid = 4'hF;
    req_data  = 32'h01020304;
    out_ready = 1'b1;
    step();
    step();
    checks++;
    if ({out_valid, out_data, out_id, out_last, busy, req_ready} !== 17'h0) begin
      failures++;
      $display("FAIL reset_outputs got=%h exp=0",
               {out_valid, out_data, out_id, out_last, busy, req_ready});
    end
    reset_n = 1'b1;
    step();
    checks++;
    if ({busy, req_ready, out_valid} !== {1'b1, 4'b0001, 1'b0}) begin
      failures++;
      $display("FAIL reset_first_grant got busy=%b ready=%b valid=%b exp busy=1 ready=0001 valid=0",
               busy, req_ready, out_valid);
    end
    step();
    checks++;
    if ({out_valid, out_id, out_last, out_data} !== {1'b1, 2'd0, 1'b0, 8'd4}) begin
      failures++;
      $display("FAIL reset_first_beat got v=%b id=%0d last=%b data=%0d exp v=1 id=0 last=0 data=4",
               out_valid, out_id, out_last, out_data);
    end
  endtask

  task automatic test_single_burst;
    logic [7:0] vin [4];
    logic [7:0] vexp [4];
    vin  = '{8'd5, 8'hFD, 8'h80, 8'h7F};
    vexp = '{8'd5, 8'd0, 8'd0, 8'd127};
    do_reset();
    req_valid = 4'b0100;
    set_data(2, vin[0]);
    step();
    checks++;
    if ({busy, req_ready, out_valid} !== {1'b1, 4'b0100, 1'b0}) begin
      failures++;
      $display("FAIL single_grant got busy=%b ready=%b valid=%b exp busy=1 ready=0100 valid=0",
               busy, req_ready, out_valid);
    end
    for (int b = 0; b < 4; b++) begin
      step();
      checks++;
      if ({out_valid, out_id, out_last, out_data} !== {1'b1, 2'd2, (b == 3), vexp[b]}) begin
        failures++;
        $display("FAIL single_beat%0d got v=%b id=%0d last=%b data=%0d exp v=1 id=2 last=%0d data=%0d",
                 b, out_valid, out_id, out_last, out_data, (b == 3), vexp[b]);
      end
      if (b < 3) set_data(2, vin[b+1]);
      else req_valid = 4'b0000;
    end
    step();
    checks++;
    if ({out_valid, busy} !== 2'b00) begin
      failures++;
      $display("FAIL single_drain got valid=%b busy=%b exp 0 0", out_valid, busy);
    end
  endtask

  task automatic test_round_robin;
    int beat;
    int cyc;
    int last_cyc;
    int exp_id;
    int gap;
    do_reset();
    for (int i = 0; i < 4; i++) set_data(i, 8'(i * 10 + 1));
    req_valid = 4'hF;
    beat      = 0;
    cyc       = 0;
    last_cyc  = 0;
    while (beat < 20 && cyc < 200) begin
      step();
      cyc++;
      if (out_valid) begin
        exp_id = (beat / 4) % 4;
        checks++;
        if ({out_id, out_last, out_data} !== {2'(exp_id), (beat % 4 == 3), 8'(exp_id * 10 + 1)}) begin
          failures++;
          $display("FAIL rr_beat%0d got id=%0d last=%b data=%0d exp id=%0d last=%0d data=%0d",
                   beat, out_id, out_last, out_data, exp_id, (beat % 4 == 3), exp_id * 10 + 1);
        end
        if (beat > 0) begin
          gap = (beat % 4 == 0) ? 2 : 1;
          checks++;
          if (cyc - last_cyc != gap) begin
            failures++;
            $display("FAIL rr_gap%0d got=%0d exp=%0d", beat, cyc - last_cyc, gap);
          end
        end
        last_cyc = cyc;
        beat++;
      end
    end
    checks++;
    if (beat != 20) begin
      failures++;
      $display("FAIL rr_timeout got beats=%0d exp=20", beat);
    end
    req_valid = 4'h0;
  endtask

  task automatic test_backpressure;
    do_reset();
    req_valid = 4'b0001;
    set_data(0, 8'd1);
    step();
    step();
    set_data(0, 8'd2);
    step();
    checks++;
    if ({out_valid, out_id, out_data} !== {1'b1, 2'd0, 8'd2}) begin
      failures++;
      $display("FAIL bp_pre got v=%b id=%0d data=%0d exp v=1 id=0 data=2", out_valid, out_id, out_data);
    end
    out_ready = 1'b0;
    set_data(0, 8'd3);
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if ({out_valid, out_id, out_last, out_data, req_ready} !== {1'b1, 2'd0, 1'b0, 8'd2, 4'b0000}) begin
        failures++;
        $display("FAIL bp_stall%0d got v=%b id=%0d last=%b data=%0d ready=%b exp v=1 id=0 last=0 data=2 ready=0000",
                 k, out_valid, out_id, out_last, out_data, req_ready);
      end
    end
    out_ready = 1'b1;
    step();
    checks++;
    if ({out_valid, out_last, out_data} !== {1'b1, 1'b0, 8'd3}) begin
      failures++;
      $display("FAIL bp_resume3 got v=%b last=%b data=%0d exp v=1 last=0 data=3", out_valid, out_last, out_data);
    end
    set_data(0, 8'd4);
    step();
    checks++;
    if ({out_valid, out_last, out_data} !== {1'b1, 1'b1, 8'd4}) begin
      failures++;
      $display("FAIL bp_resume4 got v=%b last=%b data=%0d exp v=1 last=1 data=4", out_valid, out_last, out_data);
    end
    req_valid = 4'h0;
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL bp_drain got valid=%b exp 0", out_valid);
    end
  endtask

  task automatic test_lock;
    do_reset();
    req_valid = 4'b1001;
    set_data(0, 8'd10);
    set_data(3, 8'hF9);
    step();
    step();
    set_data(0, 8'd20);
    step();
    checks++;
    if ({out_valid, out_id, out_data} !== {1'b1, 2'd0, 8'd20}) begin
      failures++;
      $display("FAIL lock_beat2 got v=%b id=%0d data=%0d exp v=1 id=0 data=20", out_valid, out_id, out_data);
    end
    req_valid = 4'b1000;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if ({busy, req_ready, out_valid} !== {1'b1, 4'b0001, 1'b0}) begin
        failures++;
        $display("FAIL lock_hold%0d got busy=%b ready=%b valid=%b exp busy=1 ready=0001 valid=0",
                 k, busy, req_ready, out_valid);
      end
    end
    req_valid = 4'b1001;
    set_data(0, 8'd30);
    step();
    checks++;
    if ({out_valid, out_id, out_last, out_data} !== {1'b1, 2'd0, 1'b0, 8'd30}) begin
      failures++;
      $display("FAIL lock_beat3 got v=%b id=%0d last=%b data=%0d exp v=1 id=0 last=0 data=30",
               out_valid, out_id, out_last, out_data);
    end
    set_data(0, 8'd40);
    step();
    checks++;
    if ({out_valid, out_id, out_last, out_data} !== {1'b1, 2'd0, 1'b1, 8'd40}) begin
      failures++;
      $display("FAIL lock_beat4 got v=%b id=%0d last=%b data=%0d exp v=1 id=0 last=1 data=40",
               out_valid, out_id, out_last, out_data);
    end
    step();
    checks++;
    if ({busy, req_ready} !== {1'b1, 4'b1000}) begin
      failures++;
      $display("FAIL lock_next_grant got busy=%b ready=%b exp busy=1 ready=1000", busy, req_ready);
    end
    step();
    checks++;
    if ({out_valid, out_id, out_last, out_data} !== {1'b1, 2'd3, 1'b0, 8'd0}) begin
      failures++;
      $display("FAIL lock_req3_beat got v=%b id=%0d last=%b data=%0d exp v=1 id=3 last=0 data=0",
               out_valid, out_id, out_last, out_data);
    end
    req_valid = 4'h0;
  endtask

  task automatic test_mid_reset;
    do_reset();
    req_valid = 4'b0100;
    set_data(2, 8'd9);
    set_data(0, 8'd6);
    step();
    step();
    step();
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, out_data, out_id, out_last, busy, req_ready} !== 17'h0) begin
      failures++;
      $display("FAIL midrst_clear got=%h exp=0", {out_valid, out_data, out_id, out_last, busy, req_ready});
    end
    req_valid = 4'b0101;
    step();
    step();
    reset_n = 1'b1;
    step();
    checks++;
    if ({busy, req_ready, out_valid} !== {1'b1, 4'b0001, 1'b0}) begin
      failures++;
      $display("FAIL midrst_grant got busy=%b ready=%b valid=%b exp busy=1 ready=0001 valid=0",
               busy, req_ready, out_valid);
    end
    step();
    checks++;
    if ({out_valid, out_id, out_last, out_data} !== {1'b1, 2'd0, 1'b0, 8'd6}) begin
      failures++;
      $display("FAIL midrst_beat got v=%b id=%0d last=%b data=%0d exp v=1 id=0 last=0 data=6",
               out_valid, out_id, out_last, out_data);
    end
    req_valid = 4'h0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_burst();
    test_round_robin();
    test_backpressure();
    test_lock();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
